i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (responder) for the 7-bit addressing mode of the Wishbone-to-I2C initiator; answers the initiator's START / address / 4-byte-data / STOP frames.
- Oversamples SCL/SDA on the system clock. Write data goes out as a 32-bit word on a local receive port. Read data is fetched 32 bits at a time from a local transmit port.
- SDA is open-drain: pulls low only. The top level builds the tristate from sda_oe_o.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit I2C address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- clk_i  in  1  system clock; must be at least 20x the SCL rate.
- rst_ni  in  1  asynchronous active-low reset.
- scl_i  in  1  raw SCL from pad.
- sda_i  in  1  raw SDA from pad.
- sda_oe_o  out  1  1 = drive SDA low; 0 = release.
- rx_dat_o  out  32  received write data, first byte in [31:24].
- rx_bytes_o  out  3  valid byte count of rx_dat_o (1..4), left-aligned.
- rx_valid_o  out  1  one-cycle strobe; rx_dat_o/rx_bytes_o valid.
- tx_dat_i  in  32  read data; [31:24] is sent first.
- tx_req_o  out  1  one-cycle strobe; tx_dat_i is captured in the same cycle.
- busy_o  out  1  high from addressed START to STOP.

Behaviour:
- Reset (async assert, sync deassert): sda_oe_o=0, rx_valid_o=0, tx_req_o=0, busy_o=0, rx_dat_o=0, rx_bytes_o=0, state IDLE.
- Input conditioning:
  - scl_i/sda_i pass through SYNC_STAGES flops, plus one history flop each.
  - scl_rise / scl_fall = edges of the synchronized SCL.
  - START = synchronized SDA 1->0 while SCL high. STOP = SDA 0->1 while SCL high.
- Timing rules:
  - Data is sampled on scl_rise.
  - sda_oe_o changes only in the cycle after scl_fall, or on STOP/START.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE: on START -> ADDR, bit counter = 0.
- ADDR:
  - Shift in 8 bits (7 address + R/W) on scl_rise.
  - After the 8th bit's scl_fall: if the address equals TARGET_ADDR -> ADDR_ACK, set sda_oe_o=1, busy_o=1. Otherwise -> WAIT_STOP with SDA released.
- ADDR_ACK:
  - Hold the ACK low through the 9th SCL high.
  - On the following scl_fall: if R/W=0 -> WR_BYTE with sda_oe_o=0.
  - If R/W=1 -> RD_BYTE; pulse tx_req_o, load the shift register from tx_dat_i, and drive bit 7 of byte 0 (sda_oe_o = ~bit) in that same cycle.
- WR_BYTE:
  - Shift 8 bits into word[31-8k -: 8], where k = byte index 0..3.
  - After the 8th scl_fall -> WR_ACK with sda_oe_o=1; release on the next scl_fall.
  - If k was 3: pulse rx_valid_o with rx_bytes_o=4, then k wraps to 0 and the word is cleared.
- RD_BYTE:
  - Drive ~bit on each scl_fall, MSB first.
  - After the 8th bit's scl_fall, release SDA -> RD_ACK.
- RD_ACK:
  - Sample SDA on scl_rise. 0 (ACK) -> RD_BYTE next byte. After byte 3 the next byte comes from a fresh tx_req_o/tx_dat_i capture.
  - 1 (NACK) -> WAIT_STOP with SDA released.
- WAIT_STOP: ignore bits until STOP or START.
- STOP in any state -> IDLE; sda_oe_o=0 the next cycle; busy_o=0.
  - If a write was in progress with k>0, pulse rx_valid_o with rx_bytes_o=k.
  - A partial byte (1..7 bits) is discarded.
- Repeated START in any state -> ADDR; same partial-word flush as STOP; busy_o stays 1.
- START/STOP detection has priority over the data edge detected in the same cycle.
- rx_valid_o and tx_req_o never assert in the same cycle; each is exactly one clk_i wide.
- No clock stretching: tx_dat_i must be valid whenever tx_req_o pulses.

Decomposition:
- Shared package i2c_pkg: state encoding constants (3-bit), I2C_ACK=0, I2C_NACK=1, BYTES_PER_WORD=4.
- Sub-module i2c_line_cond: synchronizers plus START/STOP/scl_rise/scl_fall detection. It is reusable by the initiator.

Test Plan:
- Write 4 bytes: START, 0xA0, DE AD BE EF, STOP -> ACK on all 5 bytes; rx_valid_o once with rx_dat_o=32'hDEADBEEF, rx_bytes_o=4; busy_o low after STOP.
- Read: tx_dat_i=32'h12345678; START, 0xA1; master ACKs 3 bytes, NACKs the 4th; STOP -> bytes 12 34 56 78 on SDA; exactly one tx_req_o; SDA released after byte 4.
- Address mismatch: START, 0x42 -> SDA never driven; no rx_valid_o or tx_req_o; busy_o stays 0; next frame to 0xA0 is ACKed normally.
- Partial write: START, 0xA0, AB CD, STOP -> rx_valid_o with rx_dat_o=32'hABCD0000, rx_bytes_o=2.
- Repeated START: START, 0xA0, 11 + 3 bits, Sr, 0xA1, read byte, NACK, STOP -> rx_dat_o=32'h11000000 with rx_bytes_o=1; one tx_req_o; read data correct.
- Reset mid-ACK: assert rst_ni low while sda_oe_o=1 -> sda_oe_o=0 immediately, without waiting for a clock edge; after release, IDLE ignores bits until the next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target and its line conditioner.
//   - i2c_state_e  : 3-bit target FSM state encoding
//   - I2C_ACK/NACK : SDA level seen during the acknowledge bit
//   - byte/word sizing constants and a helper that packs a byte into a word
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StAddr     = 3'd1,
        StAddrAck  = 3'd2,
        StWrByte   = 3'd3,
        StWrAck    = 3'd4,
        StRdByte   = 3'd5,
        StRdAck    = 3'd6,
        StWaitStop = 3'd7
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);
    localparam logic [2:0]  FULL_WORD_CNT  = 3'(BYTES_PER_WORD);
    localparam logic [3:0]  BITS_PER_BYTE  = 4'd8;

    // Fewer than two flops would leave metastability on the sampled lines.
    localparam int unsigned SYNC_MIN = 2;

    // Place byte b into word, byte 0 occupying [31:24].
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        unique case (idx)
            2'd0: r[31:24] = b;
            2'd1: r[23:16] = b;
            2'd2: r[15:8]  = b;
            2'd3: r[7:0]   = b;
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: synchronizes raw SCL/SDA into the system clock domain and
// detects bus events.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   scl_raw/sda_raw: pad inputs
//   sda            : synchronized SDA level
//   scl_rise/fall  : one-cycle strobes on synchronized SCL edges
//   start_det      : SDA 1->0 while SCL high
//   stop_det       : SDA 0->1 while SCL high
module i2c_line_cond
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int unsigned STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync_q;
    logic [STAGES-1:0] sda_sync_q;
    logic              scl_hist_q;
    logic              sda_hist_q;
    logic              scl_s;
    logic              sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_raw};
            sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_raw};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[STAGES-1];
    assign sda_s = sda_sync_q[STAGES-1];
    assign sda   = sda_s;

    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;

    // SCL must be high in both samples so an SDA change racing an SCL edge
    // is never taken as START/STOP.
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C target with 32-bit local data ports.
//   clk_i, rst_ni : system clock (>= 20x SCL), asynchronous active-low reset
//   scl_i, sda_i  : raw bus inputs
//   sda_oe_o      : 1 pulls SDA low, 0 releases it (open drain)
//   rx_dat_o      : received write word, first byte in [31:24]
//   rx_bytes_o    : number of valid left-aligned bytes in rx_dat_o
//   rx_valid_o    : one-cycle strobe qualifying rx_dat_o/rx_bytes_o
//   tx_dat_i      : read word, [31:24] sent first
//   tx_req_o      : one-cycle strobe; tx_dat_i captured on the edge raising it
//   busy_o        : high while addressed, from matching START to STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    output logic [31:0] rx_dat_o,
    output logic [2:0]  rx_bytes_o,
    output logic        rx_valid_o,
    input  logic [31:0] tx_dat_i,
    output logic        tx_req_o,
    output logic        busy_o
);

    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;

    i2c_state_e  state_q;
    logic [3:0]  bit_cnt_q;   // bits shifted in, or bits driven out
    logic [7:0]  shreg_q;
    logic        rw_q;
    logic [1:0]  byte_idx_q;  // byte position within the current word
    logic [31:0] word_q;      // write word being assembled
    logic [31:0] tx_sh_q;     // read word, next bit to drive in [31]
    logic        fetch_q;     // next read byte needs a fresh tx word
    logic        wr_active;
    logic        last_byte;

    i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_cond (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .scl_raw   (scl_i),
        .sda_raw   (sda_i),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign wr_active = (state_q == StWrByte) || (state_q == StWrAck);
    assign last_byte = (byte_idx_q == LAST_BYTE_IDX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            byte_idx_q <= '0;
            word_q     <= '0;
            tx_sh_q    <= '0;
            fetch_q    <= 1'b0;
            sda_oe_o   <= 1'b0;
            rx_dat_o   <= '0;
            rx_bytes_o <= '0;
            rx_valid_o <= 1'b0;
            tx_req_o   <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            tx_req_o   <= 1'b0;

            if (start_det || stop_det) begin
                // Flush completed bytes of an unfinished write word; any
                // partially shifted byte is dropped.
                if (wr_active && (byte_idx_q != 2'd0)) begin
                    rx_valid_o <= 1'b1;
                    rx_dat_o   <= word_q;
                    rx_bytes_o <= {1'b0, byte_idx_q};
                end
                word_q     <= '0;
                byte_idx_q <= '0;
                bit_cnt_q  <= '0;
                fetch_q    <= 1'b0;
                sda_oe_o   <= 1'b0;
                if (start_det) begin
                    state_q <= StAddr;
                end else begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end

                    StAddr: begin
                        if (scl_rise && (bit_cnt_q < BITS_PER_BYTE)) begin
                            shreg_q   <= {shreg_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                            if (shreg_q[7:1] == TARGET_ADDR) begin
                                rw_q     <= shreg_q[0];
                                sda_oe_o <= 1'b1;
                                busy_o   <= 1'b1;
                                state_q  <= StAddrAck;
                            end else begin
                                sda_oe_o <= 1'b0;
                                busy_o   <= 1'b0;
                                state_q  <= StWaitStop;
                            end
                        end
                    end

                    StAddrAck: begin
                        if (scl_fall) begin
                            byte_idx_q <= '0;
                            if (!rw_q) begin
                                sda_oe_o  <= 1'b0;
                                word_q    <= '0;
                                bit_cnt_q <= '0;
                                state_q   <= StWrByte;
                            end else begin
                                // The first data bit must be on SDA before
                                // SCL rises again, so fetch and drive now.
                                tx_req_o  <= 1'b1;
                                sda_oe_o  <= ~tx_dat_i[31];
                                tx_sh_q   <= {tx_dat_i[30:0], 1'b0};
                                bit_cnt_q <= 4'd1;
                                state_q   <= StRdByte;
                            end
                        end
                    end

                    StWrByte: begin
                        if (scl_rise && (bit_cnt_q < BITS_PER_BYTE)) begin
                            shreg_q   <= {shreg_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                            sda_oe_o <= 1'b1;
                            state_q  <= StWrAck;
                            if (last_byte) begin
                                rx_valid_o <= 1'b1;
                                rx_dat_o   <= put_byte(word_q, byte_idx_q, shreg_q);
                                rx_bytes_o <= FULL_WORD_CNT;
                                word_q     <= '0;
                                byte_idx_q <= '0;
                            end else begin
                                word_q     <= put_byte(word_q, byte_idx_q, shreg_q);
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end
                    end

                    StWrAck: begin
                        if (scl_fall) begin
                            sda_oe_o  <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= StWrByte;
                        end
                    end

                    StRdByte: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == BITS_PER_BYTE) begin
                                sda_oe_o <= 1'b0;
                                state_q  <= StRdAck;
                            end else if (fetch_q) begin
                                tx_req_o  <= 1'b1;
                                sda_oe_o  <= ~tx_dat_i[31];
                                tx_sh_q   <= {tx_dat_i[30:0], 1'b0};
                                fetch_q   <= 1'b0;
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end else begin
                                sda_oe_o  <= ~tx_sh_q[31];
                                tx_sh_q   <= {tx_sh_q[30:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                bit_cnt_q <= '0;
                                state_q   <= StRdByte;
                                if (last_byte) begin
                                    fetch_q    <= 1'b1;
                                    byte_idx_q <= '0;
                                end else begin
                                    byte_idx_q <= byte_idx_q + 2'd1;
                                end
                            end else begin
                                sda_oe_o <= 1'b0;
                                state_q  <= StWaitStop;
                            end
                        end
                    end

                    StWaitStop: begin
                    end

                    default: begin
                        sda_oe_o <= 1'b0;
                        state_q  <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level bench for i2c_target. A behavioural I2C master
// drives SCL/SDA; expected ACKs, received words and read bytes come from the
// frame contents, not from the design's internals.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int          Q   = 5;       // clocks per quarter SCL period
    localparam logic [6:0]  TGT = 7'h50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [31:0] rx_dat;
    logic [2:0]  rx_bytes;
    logic        rx_valid;
    logic [31:0] tx_dat;
    logic        tx_req;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Monitor state
    int unsigned tx_cnt = 0;
    int unsigned rx_cnt = 0;
    int unsigned oe_cnt = 0;
    int unsigned clash_cnt = 0;
    logic [34:0] rx_log [0:63];

    // Stimulus data
    logic [7:0]  wbytes [0:15];
    logic [31:0] tx_words [0:15];
    int unsigned tx_base = 0;
    logic [3:0]  tx_sel;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;
    assign tx_sel  = 4'(tx_cnt - tx_base);
    assign tx_dat  = tx_words[tx_sel];

    i2c_target #(
        .TARGET_ADDR (TGT),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .rx_dat_o   (rx_dat),
        .rx_bytes_o (rx_bytes),
        .rx_valid_o (rx_valid),
        .tx_dat_i   (tx_dat),
        .tx_req_o   (tx_req),
        .busy_o     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] <= {rx_bytes, rx_dat};
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (rx_valid && tx_req) clash_cnt <= clash_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus primitives; all except do_start expect SCL low on entry.
    task automatic do_start;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic do_stop;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        wait_clk(Q);
        sda_m = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        s = sda_bus;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] b, output logic ack_seen);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(m_ack, ack_seen);
    endtask

    // One complete frame; reads ACK every byte but the last.
    task automatic run_frame(input logic [6:0] addr, input logic rw, input int n,
                             input string name);
        logic        ack;
        logic        ack_seen;
        logic        matched;
        logic [7:0]  b;
        logic [31:0] w;
        int unsigned rx0, tx0, oe0;
        int          exp_rx, exp_tx, cnt;
        matched = (addr == TGT);
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        oe0 = oe_cnt;
        tx_base = tx_cnt;
        do_start;
        send_byte({addr, rw}, ack);
        check_eq({name, " addr_ack"}, 35'(ack), 35'(matched ? I2C_ACK : I2C_NACK));
        check_eq({name, " busy"}, 35'(busy), 35'(matched));
        if (matched && !rw) begin
            for (int i = 0; i < n; i++) begin
                send_byte(wbytes[i], ack);
                check_eq({name, " data_ack"}, 35'(ack), 35'(I2C_ACK));
            end
        end else if (matched && rw) begin
            for (int i = 0; i < n; i++) begin
                recv_byte((i == n - 1) ? I2C_NACK : I2C_ACK, b, ack_seen);
                w = tx_words[i / 4];
                check_eq({name, " rd_byte"}, 35'(b), 35'(w[31 - 8 * (i % 4) -: 8]));
                if (i == n - 1) check_eq({name, " released"}, 35'(ack_seen), 35'(I2C_NACK));
            end
        end
        do_stop;
        wait_clk(4);
        check_eq({name, " busy_after"}, 35'(busy), 35'(0));
        exp_rx = (matched && !rw) ? (n + 3) / 4 : 0;
        exp_tx = (matched && rw) ? (n + 3) / 4 : 0;
        check_eq({name, " rx_count"}, 35'(rx_cnt - rx0), 35'(exp_rx));
        for (int e = 0; e < exp_rx; e++) begin
            cnt = n - 4 * e;
            if (cnt > 4) cnt = 4;
            w = '0;
            for (int j = 0; j < cnt; j++) w[31 - 8 * j -: 8] = wbytes[4 * e + j];
            check_eq({name, " rx_word"}, rx_log[(rx0 + e) % 64], {3'(cnt), w});
        end
        check_eq({name, " tx_count"}, 35'(tx_cnt - tx0), 35'(exp_tx));
        check_eq({name, " sda_driven"}, 35'(oe_cnt != oe0), 35'(matched));
    endtask

    initial begin
        logic        ack;
        logic        s;
        logic [7:0]  b;
        logic [6:0]  addr;
        logic [31:0] w;
        int unsigned rx0, tx0, oe0;

        for (int i = 0; i < 16; i++) begin
            wbytes[i]   = 8'($urandom);
            tx_words[i] = $urandom;
        end

        // Reset values
        wait_clk(3);
        check_eq("rst sda_oe", 35'(sda_oe), 35'(0));
        check_eq("rst rx_valid", 35'(rx_valid), 35'(0));
        check_eq("rst tx_req", 35'(tx_req), 35'(0));
        check_eq("rst busy", 35'(busy), 35'(0));
        check_eq("rst rx_dat", 35'(rx_dat), 35'(0));
        check_eq("rst rx_bytes", 35'(rx_bytes), 35'(0));
        rst_n = 1'b1;
        wait_clk(5);

        // Full word write
        wbytes[0] = 8'hDE; wbytes[1] = 8'hAD; wbytes[2] = 8'hBE; wbytes[3] = 8'hEF;
        run_frame(TGT, 1'b0, 4, "wr4");

        // Four-byte read, last byte NACKed
        tx_words[0] = 32'h12345678;
        run_frame(TGT, 1'b1, 4, "rd4");

        // Address 0x42 on the wire, then a normal frame
        run_frame(7'h21, 1'b0, 2, "nomatch");
        wbytes[0] = 8'h5A;
        run_frame(TGT, 1'b0, 1, "after_nomatch");

        // Partial word
        wbytes[0] = 8'hAB; wbytes[1] = 8'hCD;
        run_frame(TGT, 1'b0, 2, "partial");

        // Repeated START: one full byte plus 3 bits, then a one-byte read
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        tx_base = tx_cnt;
        tx_words[0] = $urandom;
        do_start;
        send_byte(8'hA0, ack);
        check_eq("rs addr_ack", 35'(ack), 35'(I2C_ACK));
        send_byte(8'h11, ack);
        check_eq("rs data_ack", 35'(ack), 35'(I2C_ACK));
        send_bit(1'b1, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        do_start;
        wait_clk(2);
        check_eq("rs busy_held", 35'(busy), 35'(1));
        check_eq("rs rx_count", 35'(rx_cnt - rx0), 35'(1));
        check_eq("rs rx_word", rx_log[rx0 % 64], {3'd1, 32'h11000000});
        send_byte(8'hA1, ack);
        check_eq("rs raddr_ack", 35'(ack), 35'(I2C_ACK));
        recv_byte(I2C_NACK, b, s);
        w = tx_words[0];
        check_eq("rs rd_byte", 35'(b), 35'(w[31:24]));
        do_stop;
        wait_clk(4);
        check_eq("rs tx_count", 35'(tx_cnt - tx0), 35'(1));
        check_eq("rs busy_after", 35'(busy), 35'(0));

        // Reset while the address ACK is being driven
        do_start;
        for (int i = 7; i >= 0; i--) begin
            b = 8'hA0;
            send_bit(b[i], s);
        end
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        check_eq("rstack oe_before", 35'(sda_oe), 35'(1));
        rst_n = 1'b0;
        #1;
        check_eq("rstack oe_async", 35'(sda_oe), 35'(0));
        check_eq("rstack busy_async", 35'(busy), 35'(0));
        wait_clk(3);
        scl = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        oe0 = oe_cnt;
        rx0 = rx_cnt;
        send_byte(8'hA0, ack);
        check_eq("idle addr_ignored", 35'(ack), 35'(I2C_NACK));
        send_byte(8'h3C, ack);
        check_eq("idle data_ignored", 35'(ack), 35'(I2C_NACK));
        check_eq("idle no_drive", 35'(oe_cnt - oe0), 35'(0));
        check_eq("idle busy", 35'(busy), 35'(0));
        do_stop;
        wait_clk(4);
        check_eq("idle no_rx", 35'(rx_cnt - rx0), 35'(0));
        wbytes[0] = 8'h77; wbytes[1] = 8'h01; wbytes[2] = 8'hFE;
        run_frame(TGT, 1'b0, 3, "after_reset");

        // Randomized frames
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 16; i++) begin
                wbytes[i]   = 8'($urandom);
                tx_words[i] = $urandom;
            end
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TGT;
            run_frame(addr, 1'($urandom), int'($urandom_range(1, 9)), "rand");
        end

        check_eq("rx_tx_overlap", 35'(clash_cnt), 35'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
